// File: rtl/wash_sequencer_param.sv
// Washing-machine sequencer: soap wash, RINSE_COUNT rinses, then spin.
// Adds pause, fill/drain watchdog and door-integrity fault latching.
module wash_sequencer_param #(
    parameter int CNT_W         = 16,
    parameter int WASH_TICKS    = 1000,
    parameter int RINSE_TICKS   = 500,
    parameter int SPIN_TICKS    = 800,
    parameter int RINSE_COUNT   = 2,
    parameter int TIMEOUT_TICKS = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       door_close,
    input  logic       filled,
    input  logic       drained,
    input  logic       detergent_added,
    input  logic       pause,
    output logic       door_lock,
    output logic       motor_on,
    output logic       spin_on,
    output logic       fill_valve_on,
    output logic       drain_valve_on,
    output logic       detergent_req,
    output logic       done,
    output logic       fault,
    output logic [2:0] state_o,
    output logic [2:0] rinse_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FILL      = 3'd1,
        S_DETERGENT = 3'd2,
        S_AGITATE   = 3'd3,
        S_DRAIN     = 3'd4,
        S_SPIN      = 3'd5,
        S_DONE      = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_TICKS - 1);
    localparam logic [CNT_W-1:0] RINSE_LAST = CNT_W'(RINSE_TICKS - 1);
    localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_TICKS - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [2:0]       RINSE_N    = 3'(RINSE_COUNT);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] timer_d;
    logic [2:0]       rinse_q;
    logic [2:0]       rinse_d;
    logic             rphase_q;
    logic             rphase_d;
    logic [2:0]       rinse_inc;
    logic [CNT_W-1:0] agit_last;
    logic             door_bad;
    logic             timer_run;

    assign agit_last = rphase_q ? RINSE_LAST : WASH_LAST;
    assign rinse_inc = rinse_q + {2'b00, rphase_q};
    assign door_bad  = !door_close &&
                       (state_q inside {S_FILL, S_DETERGENT, S_AGITATE,
                                        S_DRAIN, S_SPIN});

    always_comb begin
        state_d   = state_q;
        rinse_d   = rinse_q;
        rphase_d  = rphase_q;
        timer_run = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && door_close) begin
                    state_d  = S_FILL;
                    rinse_d  = '0;
                    rphase_d = 1'b0;
                end
            end
            S_FILL: begin
                timer_run = 1'b1;
                if (timer_q == TO_LAST)
                    state_d = S_FAULT;
                else if (filled)
                    state_d = rphase_q ? S_AGITATE : S_DETERGENT;
            end
            S_DETERGENT: begin
                if (detergent_added)
                    state_d = S_AGITATE;
            end
            S_AGITATE: begin
                timer_run = !pause;
                if (!pause && timer_q == agit_last)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                timer_run = 1'b1;
                if (timer_q == TO_LAST) begin
                    state_d = S_FAULT;
                end else if (drained) begin
                    // rinse_inc only counts passes that were rinses
                    rinse_d  = rinse_inc;
                    rphase_d = 1'b1;
                    state_d  = (rinse_inc < RINSE_N) ? S_FILL : S_SPIN;
                end
            end
            S_SPIN: begin
                timer_run = !pause;
                if (!pause && timer_q == SPIN_LAST)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (!door_close)
                    state_d = S_IDLE;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
        endcase
        if (door_bad) begin
            state_d  = S_FAULT;
            rinse_d  = rinse_q;
            rphase_d = rphase_q;
        end
    end

    assign timer_d = (state_d != state_q) ? '0 :
                     timer_q + {{(CNT_W-1){1'b0}}, timer_run};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            rinse_q        <= '0;
            rphase_q       <= 1'b0;
            door_lock      <= 1'b0;
            motor_on       <= 1'b0;
            spin_on        <= 1'b0;
            fill_valve_on  <= 1'b0;
            drain_valve_on <= 1'b0;
            detergent_req  <= 1'b0;
            done           <= 1'b0;
            fault          <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            rinse_q        <= rinse_d;
            rphase_q       <= rphase_d;
            door_lock      <= (state_d != S_IDLE) && (state_d != S_DONE);
            motor_on       <= (state_d == S_AGITATE) && !pause;
            spin_on        <= (state_d == S_SPIN) && !pause;
            fill_valve_on  <= (state_d == S_FILL);
            drain_valve_on <= (state_d inside {S_DRAIN, S_SPIN, S_FAULT});
            detergent_req  <= (state_d == S_DETERGENT);
            done           <= (state_d == S_DONE);
            fault          <= (state_d == S_FAULT);
        end
    end

    assign state_o = state_q;
    assign rinse_o = rinse_q;

endmodule

// File: tb/tb_wash_sequencer_param.sv
// Bench for wash_sequencer_param: directed scenarios plus random
// stimulus, all checked against a countdown-based programme model.
module tb_wash_sequencer_param;

    localparam int WT = 4;
    localparam int RT = 3;
    localparam int ST = 5;
    localparam int RC = 2;
    localparam int TO = 8;

    localparam int IDLE  = 0;
    localparam int FILL  = 1;
    localparam int DET   = 2;
    localparam int AGIT  = 3;
    localparam int DRAIN = 4;
    localparam int SPIN  = 5;
    localparam int DONE  = 6;
    localparam int FAULT = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       door_close = 1'b0;
    logic       filled = 1'b0;
    logic       drained = 1'b0;
    logic       detergent_added = 1'b0;
    logic       pause = 1'b0;
    logic       door_lock;
    logic       motor_on;
    logic       spin_on;
    logic       fill_valve_on;
    logic       drain_valve_on;
    logic       detergent_req;
    logic       done;
    logic       fault;
    logic [2:0] state_o;
    logic [2:0] rinse_o;
    logic [7:0] outs;

    int n_tests = 0;
    int n_fail  = 0;

    int m_st = IDLE;
    int m_left = 0;
    int m_wait = 0;
    int m_rinse = 0;
    bit m_rinsing = 1'b0;
    bit m_pz = 1'b0;

    int seq[$];
    int mcnt[$];
    int exp_seq[13] = '{0, 1, 2, 3, 4, 1, 3, 4, 1, 3, 4, 5, 6};
    int prev, scnt, agn, ag, agm, sp, spm, fc;

    wash_sequencer_param #(
        .CNT_W(16), .WASH_TICKS(WT), .RINSE_TICKS(RT),
        .SPIN_TICKS(ST), .RINSE_COUNT(RC), .TIMEOUT_TICKS(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .door_close(door_close), .filled(filled),
        .drained(drained), .detergent_added(detergent_added),
        .pause(pause), .door_lock(door_lock),
        .motor_on(motor_on), .spin_on(spin_on),
        .fill_valve_on(fill_valve_on),
        .drain_valve_on(drain_valve_on),
        .detergent_req(detergent_req), .done(done),
        .fault(fault), .state_o(state_o), .rinse_o(rinse_o)
    );

    assign outs = {door_lock, motor_on, spin_on, fill_valve_on,
                   drain_valve_on, detergent_req, done, fault};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: remaining-tick countdowns and a wait budget per fill/drain.
    task model_step();
        int nst;
        if (reset) begin
            m_st = IDLE;
            m_rinse = 0;
            m_rinsing = 1'b0;
            m_pz = pause;
            return;
        end
        nst = m_st;
        if (!door_close && m_st >= FILL && m_st <= SPIN) begin
            nst = FAULT;
        end else begin
            case (m_st)
                IDLE: if (start && door_close) begin
                    nst = FILL;
                    m_rinse = 0;
                    m_rinsing = 1'b0;
                end
                FILL: begin
                    m_wait--;
                    if (m_wait == 0) nst = FAULT;
                    else if (filled) nst = m_rinsing ? AGIT : DET;
                end
                DET: if (detergent_added) nst = AGIT;
                AGIT: if (!pause) begin
                    m_left--;
                    if (m_left == 0) nst = DRAIN;
                end
                DRAIN: begin
                    m_wait--;
                    if (m_wait == 0) begin
                        nst = FAULT;
                    end else if (drained) begin
                        if (m_rinsing) m_rinse++;
                        if (m_rinse < RC) begin
                            nst = FILL;
                            m_rinsing = 1'b1;
                        end else begin
                            nst = SPIN;
                        end
                    end
                end
                SPIN: if (!pause) begin
                    m_left--;
                    if (m_left == 0) nst = DONE;
                end
                DONE: if (!door_close) nst = IDLE;
                default: ;
            endcase
        end
        if (nst != m_st) begin
            if (nst == FILL || nst == DRAIN) m_wait = TO;
            if (nst == AGIT) m_left = m_rinsing ? RT : WT;
            if (nst == SPIN) m_left = ST;
        end
        m_st = nst;
        m_pz = pause;
    endtask

    function automatic logic [7:0] exp_outs();
        logic [7:0] o;
        o = '0;
        o[7] = (m_st != IDLE) && (m_st != DONE);
        o[6] = (m_st == AGIT) && !m_pz;
        o[5] = (m_st == SPIN) && !m_pz;
        o[4] = (m_st == FILL);
        o[3] = (m_st == DRAIN) || (m_st == SPIN) || (m_st == FAULT);
        o[2] = (m_st == DET);
        o[1] = (m_st == DONE);
        o[0] = (m_st == FAULT);
        return o;
    endfunction

    task tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("state", state_o, m_st);
        chk("rinse", rinse_o, m_rinse);
        chk("outs", outs, exp_outs());
    endtask

    task respond();
        filled = fill_valve_on;
        detergent_added = detergent_req;
        drained = (state_o == 3'(DRAIN));
    endtask

    task do_reset();
        reset = 1'b1;
        start = 1'b0;
        filled = 1'b0;
        drained = 1'b0;
        detergent_added = 1'b0;
        pause = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task run_to_done(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (state_o == 3'(DONE)) break;
            respond();
            tick();
            start = 1'b0;
        end
        chk(tag, state_o, DONE);
    endtask

    initial begin
        tick();
        tick();
        chk("reset_state", state_o, IDLE);
        chk("reset_outs", outs, 0);
        chk("reset_rinse", rinse_o, 0);
        reset = 1'b0;

        // full programme with 1-cycle sensor answers
        door_close = 1'b1;
        start = 1'b1;
        prev = IDLE;
        seq.push_back(IDLE);
        scnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (state_o == 3'(DONE)) break;
            respond();
            tick();
            start = 1'b0;
            if (state_o != prev) begin
                seq.push_back(state_o);
                if (state_o == 3'(AGIT)) mcnt.push_back(0);
                prev = state_o;
            end
            if (motor_on && mcnt.size() > 0)
                mcnt[mcnt.size()-1]++;
            if (spin_on) scnt++;
        end
        chk("run1_done", state_o, DONE);
        chk("seq_len", seq.size(), 13);
        for (int i = 0; i < 13; i++)
            if (i < seq.size())
                chk($sformatf("seq%0d", i), seq[i], exp_seq[i]);
        chk("agit_n", mcnt.size(), 3);
        if (mcnt.size() == 3) begin
            chk("motor_soap", mcnt[0], WT);
            chk("motor_r1", mcnt[1], RT);
            chk("motor_r2", mcnt[2], RT);
        end
        chk("spin_cyc", scnt, ST);
        chk("fin_done", done, 1);
        chk("fin_lock", door_lock, 0);
        chk("fin_rinse", rinse_o, RC);

        // DONE holds until door opens; start needs a closed door
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("done_hold", done, 1);
        end
        door_close = 1'b0;
        tick();
        chk("done_exit", state_o, IDLE);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_door_idle", state_o, IDLE);
        end
        door_close = 1'b1;
        tick();
        chk("relaunch", state_o, FILL);

        // pause for 6 cycles in soap agitation and in spin
        do_reset();
        door_close = 1'b1;
        start = 1'b1;
        prev = IDLE;
        agn = 0; ag = 0; agm = 0; sp = 0; spm = 0;
        for (int i = 0; i < 300; i++) begin
            if (state_o == 3'(DONE)) break;
            respond();
            pause = 1'b0;
            if (agn == 1 && state_o == 3'(AGIT) && ag >= 3 && ag < 9)
                pause = 1'b1;
            if (state_o == 3'(SPIN) && sp >= 3 && sp < 9)
                pause = 1'b1;
            tick();
            start = 1'b0;
            if (state_o == 3'(AGIT)) begin
                if (prev != AGIT) agn++;
                if (agn == 1) begin
                    ag++;
                    if (motor_on) agm++;
                end
            end
            if (state_o == 3'(SPIN)) begin
                sp++;
                if (spin_on) spm++;
            end
            prev = state_o;
        end
        pause = 1'b0;
        chk("pause_done", state_o, DONE);
        chk("pause_agit_cyc", ag, 10);
        chk("pause_motor_cyc", agm, WT);
        chk("pause_spin_cyc", sp, ST + 6);
        chk("pause_spin_on", spm, ST);

        // fill watchdog
        do_reset();
        door_close = 1'b1;
        start = 1'b1;
        fc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            start = 1'b0;
            if (state_o == 3'(FILL)) fc++;
            if (i == 15) door_close = 1'b0;
        end
        chk("wd_fill_cyc", fc, TO);
        chk("wd_state", state_o, FAULT);
        chk("wd_outs", outs, 8'b1000_1001);

        // door opens in DRAIN while drained is reported
        do_reset();
        door_close = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (state_o == 3'(DRAIN)) break;
            respond();
            tick();
            start = 1'b0;
        end
        drained = 1'b1;
        door_close = 1'b0;
        tick();
        chk("door_drain", state_o, FAULT);
        chk("door_rinse", rinse_o, 0);

        // reset mid rinse-1 agitation, then a full rerun
        do_reset();
        door_close = 1'b1;
        start = 1'b1;
        prev = IDLE;
        agn = 0;
        for (int i = 0; i < 200; i++) begin
            respond();
            tick();
            start = 1'b0;
            if (state_o == 3'(AGIT) && prev != AGIT) agn++;
            prev = state_o;
            if (agn == 2) break;
        end
        chk("rst_pre", state_o, AGIT);
        reset = 1'b1;
        tick();
        chk("rst_state", state_o, IDLE);
        chk("rst_outs", outs, 0);
        chk("rst_rinse", rinse_o, 0);
        reset = 1'b0;
        start = 1'b1;
        run_to_done("rerun_done");
        chk("rerun_rinse", rinse_o, RC);

        // random stimulus against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 99) < 30);
            door_close = ($urandom_range(0, 99) < 97);
            filled = ($urandom_range(0, 99) < 35);
            drained = ($urandom_range(0, 99) < 35);
            detergent_added = ($urandom_range(0, 99) < 40);
            pause = ($urandom_range(0, 99) < 25);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
